// File: rtl/add8_err_monitor_if.sv
// add8_err_monitor_if: sample stream from the operand generator and adder under test.
//   IN_VALID  sample valid (generator -> monitor)
//   IN_READY  monitor can accept a sample this cycle (monitor -> generator)
//   A, B      operands, W bits
//   O         adder-under-test result, W+1 bits
// Modports: master = generator side, slave = monitor side.
interface add8_err_monitor_if #(
    parameter int unsigned W = 8
) ();
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W:0]   O;

    modport master (output IN_VALID, A, B, O, input IN_READY);
    modport slave  (input IN_VALID, A, B, O, output IN_READY);
endinterface

// File: rtl/add8_err_monitor.sv
// add8_err_monitor: streaming error characterisation for a W-bit adder under test.
// Recomputes the exact sum of every accepted sample and accumulates the error
// distance sum, the worst-case error and the count of erroneous samples over
// TARGET samples.
// Ports:
//   CLK, RST_N   clock, synchronous active-low reset
//   START        begin a run (honoured in IDLE/DONE only); latches TARGET
//   CLR          synchronous clear to IDLE from any state
//   TARGET       samples to accept in the run
//   bus          sample stream (slave side of add8_err_monitor_if)
//   SAMPLES, ED_SUM, WCE, ERR_CNT  accumulated metrics
//   MSE_SUM      sum of squared error distance (only with ADD8_ERR_MSE_EN defined)
//   BUSY, DONE   run in progress / run finished
// Optional feature macro: ADD8_ERR_MSE_EN.
module add8_err_monitor #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 17
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 CLR,
    input  logic [CNT_W-1:0]     TARGET,
    add8_err_monitor_if.slave    bus,
    output logic [CNT_W-1:0]     SAMPLES,
    output logic [W+CNT_W:0]     ED_SUM,
    output logic [W:0]           WCE,
    output logic [CNT_W-1:0]     ERR_CNT,
`ifdef ADD8_ERR_MSE_EN
    output logic [2*W+1+CNT_W:0] MSE_SUM,
`endif
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_v_q, s1_v_d;
    logic [W-1:0]       s1_a_q, s1_a_d;
    logic [W-1:0]       s1_b_q, s1_b_d;
    logic [W:0]         s1_o_q, s1_o_d;
    logic               s2_v_q, s2_v_d;
    logic [W:0]         s2_ed_q, s2_ed_d;
    logic [CNT_W-1:0]   samples_q, samples_d;
    logic [W+CNT_W:0]   ed_sum_q, ed_sum_d;
    logic [W:0]         wce_q, wce_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
`ifdef ADD8_ERR_MSE_EN
    logic [2*W+1+CNT_W:0] mse_sum_q, mse_sum_d;
    logic [2*W+1:0]       ed_sq;
`endif

    logic       in_ready;
    logic       accept;
    logic       start_run;
    logic [W:0] exact;
    logic [W:0] ed;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_o_d    = s1_o_q;
        samples_d = samples_q;
        ed_sum_d  = ed_sum_q;
        wce_d     = wce_q;
        err_cnt_d = err_cnt_q;
`ifdef ADD8_ERR_MSE_EN
        mse_sum_d = mse_sum_q;
        ed_sq     = {{(W+1){1'b0}}, s2_ed_q} * {{(W+1){1'b0}}, s2_ed_q};
`endif
        start_run = 1'b0;

        // Ready depends only on state and count, never on IN_VALID.
        in_ready = (state_q == StRun) && (cnt_q < target_q);
        accept   = in_ready && bus.IN_VALID;
        cnt_d    = cnt_q + CNT_W'(accept);

        // Stage 1: capture the sample on accept.
        s1_v_d = accept;
        if (accept) begin
            s1_a_d = bus.A;
            s1_b_d = bus.B;
            s1_o_d = bus.O;
        end

        // Stage 2: error distance of the captured sample.
        exact   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        ed      = (s1_o_q >= exact) ? (s1_o_q - exact) : (exact - s1_o_q);
        s2_v_d  = s1_v_q;
        s2_ed_d = ed;

        // Accumulate.
        if (s2_v_q) begin
            samples_d = samples_q + CNT_W'(1);
            ed_sum_d  = ed_sum_q + {{CNT_W{1'b0}}, s2_ed_q};
            if (s2_ed_q > wce_q) begin
                wce_d = s2_ed_q;
            end
            err_cnt_d = err_cnt_q + CNT_W'(s2_ed_q != '0);
`ifdef ADD8_ERR_MSE_EN
            mse_sum_d = mse_sum_q + {{CNT_W{1'b0}}, ed_sq};
`endif
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    state_d   = StRun;
                    start_run = 1'b1;
                end
            end
            StRun: begin
                // Uses the post-accept count so the last accept moves straight to DRAIN.
                if (cnt_d == target_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Stage 2 drains on this same edge, so DONE lines up with the last update.
                if (!s1_v_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_run) begin
            target_d  = TARGET;
            cnt_d     = '0;
            s1_v_d    = 1'b0;
            s2_v_d    = 1'b0;
            samples_d = '0;
            ed_sum_d  = '0;
            wce_d     = '0;
            err_cnt_d = '0;
`ifdef ADD8_ERR_MSE_EN
            mse_sum_d = '0;
`endif
        end

        // CLR wins over START and accepts; in-flight samples are dropped.
        if (CLR) begin
            state_d   = StIdle;
            target_d  = '0;
            cnt_d     = '0;
            s1_v_d    = 1'b0;
            s2_v_d    = 1'b0;
            samples_d = '0;
            ed_sum_d  = '0;
            wce_d     = '0;
            err_cnt_d = '0;
`ifdef ADD8_ERR_MSE_EN
            mse_sum_d = '0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            target_q  <= '0;
            cnt_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_o_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_ed_q   <= '0;
            samples_q <= '0;
            ed_sum_q  <= '0;
            wce_q     <= '0;
            err_cnt_q <= '0;
`ifdef ADD8_ERR_MSE_EN
            mse_sum_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_o_q    <= s1_o_d;
            s2_v_q    <= s2_v_d;
            s2_ed_q   <= s2_ed_d;
            samples_q <= samples_d;
            ed_sum_q  <= ed_sum_d;
            wce_q     <= wce_d;
            err_cnt_q <= err_cnt_d;
`ifdef ADD8_ERR_MSE_EN
            mse_sum_q <= mse_sum_d;
`endif
        end
    end

    assign bus.IN_READY = in_ready;
    assign SAMPLES      = samples_q;
    assign ED_SUM       = ed_sum_q;
    assign WCE          = wce_q;
    assign ERR_CNT      = err_cnt_q;
`ifdef ADD8_ERR_MSE_EN
    assign MSE_SUM      = mse_sum_q;
`endif
    assign BUSY         = (state_q == StRun) || (state_q == StDrain);
    assign DONE         = (state_q == StDone);

endmodule
